// File: rtl/axi_crossbar_rr_sel.sv
// axi_crossbar_rr_sel: combinational round-robin selector, first request at or above ptr, else lowest request.
module axi_crossbar_rr_sel #(
  parameter int N = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);
  logic [IW-1:0] lo_idx, hi_idx;
  logic          hi_hit;
  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    hi_hit = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) lo_idx = IW'(i);
      if (req[i] && i >= int'(ptr)) begin
        hi_idx = IW'(i);
        hi_hit = 1'b1;
      end
    end
  end
  assign valid  = |req;
  assign idx    = hi_hit ? hi_idx : lo_idx;
  assign onehot = valid ? (N'(1) << idx) : '0;
endmodule

// File: rtl/axi_crossbar_issue_arb.sv
// axi_crossbar_issue_arb: QoS/round-robin address admission arbiter with an outstanding-transaction limit.
module axi_crossbar_issue_arb #(
  parameter int S_COUNT = 4,
  parameter int M_ISSUE = 4,
  parameter int ARB_QOS = 1,
  parameter int IW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1,
  parameter int CW = $clog2(M_ISSUE + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [S_COUNT-1:0]   s_req,
  input  logic [S_COUNT*4-1:0] s_qos,
  output logic [S_COUNT-1:0]   grant,
  output logic [IW-1:0]        grant_encoded,
  output logic                 grant_valid,
  input  logic                 m_ack,
  input  logic                 cpl_valid,
  output logic [CW-1:0]        issue_count,
  output logic                 issue_full
);
  localparam int QW = 4;
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, next;
  logic [S_COUNT-1:0] elig, sel_onehot;
  logic [IW-1:0]      sel_idx, rr_ptr;
  logic               sel_valid, admit, ack;
  logic [QW-1:0]      max_qos;
  always_comb begin
    max_qos = '0;
    elig = '0;
    for (int i = 0; i < S_COUNT; i++)
      if (s_req[i] && s_qos[i*QW +: QW] > max_qos) max_qos = s_qos[i*QW +: QW];
    for (int i = 0; i < S_COUNT; i++)
      elig[i] = s_req[i] && (ARB_QOS == 0 || s_qos[i*QW +: QW] == max_qos);
  end
  axi_crossbar_rr_sel #(.N(S_COUNT), .IW(IW)) u_sel (
    .req(elig), .ptr(rr_ptr), .onehot(sel_onehot), .idx(sel_idx), .valid(sel_valid)
  );
  assign admit       = issue_count < CW'(M_ISSUE) || cpl_valid;
  assign ack         = state == GRANT && m_ack;
  assign grant_valid = state == GRANT;
  assign issue_full  = issue_count == CW'(M_ISSUE);
  always_comb begin
    next = state;
    if (state == IDLE && sel_valid && admit) next = GRANT;
    if (state == GRANT && (m_ack || !s_req[grant_encoded])) next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grant <= '0;
      grant_encoded <= '0;
      rr_ptr <= '0;
      issue_count <= '0;
    end else begin
      state <= next;
      if (state == IDLE && next == GRANT) begin
        grant <= sel_onehot;
        grant_encoded <= sel_idx;
      end
      if (state == GRANT && next == IDLE) grant <= '0;
      if (ack) rr_ptr <= (grant_encoded == IW'(S_COUNT - 1)) ? '0 : grant_encoded + 1'b1;
      if (ack && !cpl_valid) issue_count <= issue_count + 1'b1;
      else if (cpl_valid && !ack && issue_count != '0) issue_count <= issue_count - 1'b1;
    end
  end
endmodule
